chan_cmd_dispatcher: RTL and testbench

Store-and-forward dispatcher that sits directly downstream of the IPbus command manager. It consumes the single channel-TX command stream (data, dest, last, valid/ready), buffers one complete packet, then replays it on the one channel port selected by the packet's dest. A normal packet is 4 words: CSN, CC, REG_NUM, VALUE. Malformed packets are dropped and flagged: bad dest, or longer than the buffer.

---
 rtl/cmd_pkg.sv | 11 +
 rtl/chan_cmd_dispatcher_if.sv | 19 +
 rtl/cmd_pkt_buf.sv | 24 ++
 rtl/chan_cmd_dispatcher.sv | 96 +++++++++
 tb/tb_chan_cmd_dispatcher.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/cmd_pkg.sv
// cmd_pkg: shared command-path state encoding, packet geometry and word-slot indices.
//   No ports; imported by the dispatcher, its buffer users and the command manager.
package cmd_pkg;
   typedef enum logic [1:0] {IDLE, FILL, DROP, DRAIN} state_e;
   localparam int CMD_PKT_WORDS = 4;
   localparam int DEST_W        = 4;
   localparam int CSN           = 0;
   localparam int CC            = 1;
   localparam int REG_NUM       = 2;
   localparam int VALUE         = 3;
endpackage

// File: rtl/chan_cmd_dispatcher_if.sv
// chan_cmd_dispatcher_if: command stream in (s_*) and shared channel bus out (m_*).
//   master: upstream command manager plus channel ready side (drives s_*, m_ready)
//   slave : dispatcher (drives s_ready, m_data, m_last, m_valid)
interface chan_cmd_dispatcher_if #(parameter int NUM_CHAN = 5);
   import cmd_pkg::*;
   logic [31:0]         s_data;
   logic [DEST_W-1:0]   s_dest;
   logic                s_last;
   logic                s_valid;
   logic                s_ready;
   logic [31:0]         m_data;
   logic                m_last;
   logic [NUM_CHAN-1:0] m_valid;
   logic [NUM_CHAN-1:0] m_ready;
   modport master (output s_data, s_dest, s_last, s_valid, m_ready,
                   input  s_ready, m_data, m_last, m_valid);
   modport slave  (input  s_data, s_dest, s_last, s_valid, m_ready,
                   output s_ready, m_data, m_last, m_valid);
endinterface

// File: rtl/cmd_pkt_buf.sv
// cmd_pkt_buf: DEPTH x 32 packet register file, cleared on reset.
//   clk, rst_n       : clock, async active-low reset
//   we, waddr, wdata : synchronous write port
//   raddr, rdata     : asynchronous read port
module cmd_pkt_buf #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];
   assign rdata = mem[raddr];
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (we)
         mem[waddr] <= wdata;
endmodule

// File: rtl/chan_cmd_dispatcher.sv
// chan_cmd_dispatcher: store-and-forward one command packet to the channel named by its dest.
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : s_* command stream in, m_* one-hot-valid channel bus out
//   err_bad_dest   : pulse, packet dropped because dest >= NUM_CHAN
//   err_overlength : pulse, packet dropped because it exceeded MAX_WORDS
//   pkt_count      : wrapping count of forwarded packets
module chan_cmd_dispatcher
   import cmd_pkg::*;
#(
   parameter int NUM_CHAN  = 5,
   parameter int MAX_WORDS = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   chan_cmd_dispatcher_if.slave bus,
   output logic                 err_bad_dest,
   output logic                 err_overlength,
   output logic [CNT_W-1:0]     pkt_count
);
   localparam int AW = $clog2(MAX_WORDS);
   localparam int PW = AW + 1;
   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_FILL  = FILL;
   localparam logic [1:0] S_DROP  = DROP;
   localparam logic [1:0] S_DRAIN = DRAIN;
   logic [1:0]        state;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [DEST_W-1:0] dest, dst;
   logic [31:0]       rdata;
   logic              drain, s_hs, m_hs, we;
   assign drain = state == S_DRAIN;
   assign bus.s_ready = !drain;
   assign s_hs = bus.s_valid & bus.s_ready;
   assign we = s_hs & (state == S_IDLE | state == S_FILL);
   // dest is only taken from the first word; later words use the latched copy
   assign dst = state == S_IDLE ? bus.s_dest : dest;
   // wr_ptr keeps the packet length while draining
   assign bus.m_last = drain && rd_ptr == wr_ptr - PW'(1);
   assign bus.m_data = drain ? rdata : '0;
   assign m_hs = |(bus.m_valid & bus.m_ready);
   always_comb begin
      bus.m_valid = '0;
      for (int c = 0; c < NUM_CHAN; c++) bus.m_valid[c] = drain && dest == DEST_W'(c);
   end
   cmd_pkt_buf #(.DEPTH(MAX_WORDS), .AW(AW)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (bus.s_data),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rdata)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state          <= S_IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         dest           <= '0;
         err_bad_dest   <= 1'b0;
         err_overlength <= 1'b0;
         pkt_count      <= '0;
      end else begin
         err_bad_dest   <= 1'b0;
         err_overlength <= 1'b0;
         if (we) begin
            dest   <= dst;
            wr_ptr <= wr_ptr + PW'(1);
            if (bus.s_last) begin
               rd_ptr <= '0;
               if (32'(dst) >= NUM_CHAN) begin
                  err_bad_dest <= 1'b1;
                  wr_ptr       <= '0;
                  state        <= S_IDLE;
               end else
                  state <= S_DRAIN;
            end else if (wr_ptr == PW'(MAX_WORDS - 1)) begin
               // buffer full and still no last: discard the rest of this packet
               err_overlength <= 1'b1;
               wr_ptr         <= '0;
               state          <= S_DROP;
            end else
               state <= S_FILL;
         end
         if (state == S_DROP && s_hs && bus.s_last) state <= S_IDLE;
         if (m_hs) begin
            rd_ptr <= rd_ptr + PW'(1);
            if (bus.m_last) begin
               pkt_count <= pkt_count + CNT_W'(1);
               wr_ptr    <= '0;
               state     <= S_IDLE;
            end
         end
      end
endmodule

// File: tb/tb_chan_cmd_dispatcher.sv
// tb_chan_cmd_dispatcher: directed scoreboard bench for chan_cmd_dispatcher.
module tb_chan_cmd_dispatcher;
   typedef struct packed {
      logic [4:0]  v;
      logic [31:0] d;
      logic        l;
   } exp_t;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        err_bad_dest, err_overlength;
   logic [15:0] pkt_count;
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_vcyc = 0;
   exp_t        sb[$];
   chan_cmd_dispatcher_if #(.NUM_CHAN(5)) bus ();
   chan_cmd_dispatcher #(.NUM_CHAN(5), .MAX_WORDS(4), .CNT_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .err_bad_dest   (err_bad_dest),
      .err_overlength (err_overlength),
      .pkt_count      (pkt_count)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Scoreboard: every cycle with a valid beat is compared to the queue head;
   // the head is retired only when that beat is actually handshaken.
   always @(negedge clk)
      if (rst_n && bus.m_valid != 0) begin
         n_vcyc++;
         chk("s_ready_in_drain", bus.s_ready, 0);
         if (sb.size() == 0)
            chk("unexpected_valid", bus.m_valid, 0);
         else begin
            chk("m_valid", bus.m_valid, sb[0].v);
            chk("m_data", bus.m_data, sb[0].d);
            chk("m_last", bus.m_last, sb[0].l);
            if (|(bus.m_valid & bus.m_ready)) void'(sb.pop_front());
         end
      end
   task automatic put(input logic [31:0] d, input logic [3:0] ds, input logic l);
      int t = 0;
      bus.s_data  = d;
      bus.s_dest  = ds;
      bus.s_last  = l;
      bus.s_valid = 1'b1;
      @(negedge clk);
      while (!bus.s_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("s_ready_accept", bus.s_ready, 1);
      @(posedge clk);
      #1 bus.s_valid = 1'b0;
   endtask
   task automatic fwd(input logic [4:0] v, input logic [31:0] d, input logic [3:0] ds, input logic l);
      sb.push_back('{v: v, d: d, l: l});
      put(d, ds, l);
   endtask
   task automatic drain_wait();
      int t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("drain_done", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.s_data  = '0;
      bus.s_dest  = '0;
      bus.s_last  = 1'b0;
      bus.s_valid = 1'b0;
      bus.m_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_s_ready", bus.s_ready, 1);
      chk("rst_m_valid", bus.m_valid, 0);
      chk("rst_m_last", bus.m_last, 0);
      chk("rst_m_data", bus.m_data, 0);
      chk("rst_errs", {err_bad_dest, err_overlength}, 0);
      rst_n = 1'b1;
      #1 chk("rst_pkt_count", pkt_count, 0);
      // standard packet to channel 2, all channels ready
      bus.m_ready = 5'b11111;
      n_vcyc = 0;
      fwd(5'b00100, 32'h5, 4'd2, 1'b0);
      fwd(5'b00100, 32'hC0, 4'd2, 1'b0);
      fwd(5'b00100, 32'h12, 4'd2, 1'b0);
      fwd(5'b00100, 32'hDEAD, 4'd2, 1'b1);
      chk("latency_valid", bus.m_valid, 5'b00100);
      drain_wait();
      chk("std_cycles", n_vcyc, 4);
      chk("std_pkt_count", pkt_count, 1);
      chk("std_idle_ready", bus.s_ready, 1);
      // backpressure on channel 2, channel 0 always ready
      bus.m_ready = 5'b00001;
      n_vcyc = 0;
      fwd(5'b00100, 32'h5, 4'd2, 1'b0);
      fwd(5'b00100, 32'hC0, 4'd2, 1'b0);
      fwd(5'b00100, 32'h12, 4'd2, 1'b0);
      fwd(5'b00100, 32'hDEAD, 4'd2, 1'b1);
      for (int i = 0; i < 8; i++) begin
         bus.m_ready = (i % 4 == 0 || i % 4 == 3) ? 5'b00101 : 5'b00001;
         @(posedge clk);
         #1;
      end
      chk("bp_queue_empty", sb.size(), 0);
      chk("bp_cycles", n_vcyc, 8);
      chk("bp_pkt_count", pkt_count, 2);
      chk("bp_idle_ready", bus.s_ready, 1);
      bus.m_ready = 5'b11111;
      // bad dest: dropped with a one-cycle pulse
      n_vcyc = 0;
      put(32'h1, 4'd7, 1'b0);
      put(32'h2, 4'd7, 1'b0);
      put(32'h3, 4'd7, 1'b0);
      chk("bad_no_early_pulse", err_bad_dest, 0);
      put(32'h4, 4'd7, 1'b1);
      chk("bad_pulse", err_bad_dest, 1);
      chk("bad_s_ready", bus.s_ready, 1);
      @(posedge clk);
      #1;
      chk("bad_pulse_end", err_bad_dest, 0);
      chk("bad_no_valid", n_vcyc, 0);
      chk("bad_pkt_count", pkt_count, 2);
      // overlength: 6 words, pulse after the 4th, remainder swallowed
      put(32'h11, 4'd1, 1'b0);
      put(32'h22, 4'd1, 1'b0);
      put(32'h33, 4'd1, 1'b0);
      put(32'h44, 4'd1, 1'b0);
      chk("ovl_pulse", err_overlength, 1);
      put(32'h55, 4'd1, 1'b0);
      chk("ovl_pulse_end", err_overlength, 0);
      put(32'h66, 4'd1, 1'b1);
      @(posedge clk);
      #1;
      chk("ovl_no_valid", n_vcyc, 0);
      chk("ovl_no_bad_dest", err_bad_dest, 0);
      fwd(5'b00010, 32'hA1, 4'd1, 1'b0);
      fwd(5'b00010, 32'hA2, 4'd1, 1'b0);
      fwd(5'b00010, 32'hA3, 4'd1, 1'b0);
      fwd(5'b00010, 32'hA4, 4'd1, 1'b1);
      drain_wait();
      chk("ovl_next_pkt_count", pkt_count, 3);
      // counter wrap with a single-word packet
      force dut.pkt_count = 16'hFFFF;
      #1 release dut.pkt_count;
      chk("wrap_preset", pkt_count, 16'hFFFF);
      n_vcyc = 0;
      fwd(5'b10000, 32'hABCD, 4'd4, 1'b1);
      drain_wait();
      chk("wrap_cycles", n_vcyc, 1);
      chk("wrap_pkt_count", pkt_count, 0);
      // reset in the middle of a drain
      fwd(5'b01000, 32'h100, 4'd3, 1'b0);
      fwd(5'b01000, 32'h200, 4'd3, 1'b0);
      fwd(5'b01000, 32'h300, 4'd3, 1'b0);
      fwd(5'b01000, 32'h400, 4'd3, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("mid_drain_words_left", sb.size(), 2);
      chk("mid_drain_valid", bus.m_valid, 5'b01000);
      rst_n = 1'b0;
      #1;
      chk("arst_m_valid", bus.m_valid, 0);
      chk("arst_m_data", bus.m_data, 0);
      chk("arst_m_last", bus.m_last, 0);
      chk("arst_s_ready", bus.s_ready, 1);
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_s_ready", bus.s_ready, 1);
      chk("post_rst_pkt_count", pkt_count, 0);
      chk("post_rst_errs", {err_bad_dest, err_overlength}, 0);
      chk("post_rst_m_valid", bus.m_valid, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
